ps2_scancode_sequencer: RTL and testbench
=========================================

Name: ps2_scancode_sequencer

Overview:
Sequences the byte stream from the PS/2 receiver into complete key events. Tracks the E0 (extended) and F0 (break) prefixes and emits one event per finished sequence: {code, ext, brk}. Events are buffered in a small FIFO for the downstream consumer, such as the display or ALU control logic. The block also guards against stalled prefix sequences with a timeout.

Parameters:
DEPTH, 4, event FIFO depth in entries; power of two, minimum 2
TIMEOUT_CYC, 1000000, clk cycles allowed between a prefix byte and the next byte (20 ms at 50 MHz)
TO_W, 20, timeout counter width; must hold TIMEOUT_CYC-1

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
rx_data  in  8  byte from the PS/2 receiver; valid only while rx_done=1
rx_done  in  1  one-cycle strobe, one new byte
out_rd  in  1  consumer pops the head event; ignored when out_valid=0
out_valid  out  1  FIFO not empty
out_code  out  8  head event scan code (final non-prefix byte)
out_ext  out  1  head event was E0-prefixed
out_brk  out  1  head event was a break (F0-prefixed)
fifo_full  out  1  FIFO holds DEPTH entries
err_seq  out  1  one-cycle pulse on an illegal prefix order
err_to  out  1  one-cycle pulse on prefix timeout
err_ovf  out  1  one-cycle pulse when an event is dropped because the FIFO is full

Behaviour:
- Reset (async, active-high): state IDLE, timeout counter 0, FIFO empty (pointers and count 0), all outputs 0.
- Single clock domain. rx_done/rx_data are synchronous to clk.
- FSM states: IDLE, EXT, BRK, EXT_BRK. Transitions occur only on rx_done=1, except timeout.
- IDLE: E0 goes to EXT. F0 goes to BRK. Any other byte pushes {byte,0,0} and stays in IDLE.
- EXT: F0 goes to EXT_BRK. Any other non-prefix byte pushes {byte,1,0} and goes to IDLE. A repeated E0 pulses err_seq and stays in EXT.
- BRK: any non-prefix byte pushes {byte,0,1} and goes to IDLE. A repeated F0 stays in BRK with no error (tolerated duplicate). E0 pulses err_seq and goes to EXT (restarts as an extended sequence).
- EXT_BRK: any non-prefix byte pushes {byte,1,1} and goes to IDLE. E0 or F0 pulses err_seq, goes to IDLE, and nothing is pushed.
- Byte E1 (pause prefix) is unsupported. In any state it pulses err_seq, goes to IDLE, and nothing is pushed.
- Timeout counter: cleared on every rx_done and while in IDLE. It increments each cycle in EXT, BRK or EXT_BRK. When it reaches TIMEOUT_CYC-1: go to IDLE, pulse err_to, clear the counter, drop the partial sequence. If rx_done arrives in that same cycle, rx_done wins and there is no timeout.
- Latency: rx_done in cycle N for a final byte means the FIFO write happens at the end of N, and out_valid/out_* show the event from N+1 if the FIFO was empty. Head fields are read combinationally from FIFO storage at the read pointer.
- Pop: out_rd=1 with out_valid=1 advances the read pointer at the clock edge.
- Push and pop in the same cycle: both are performed and the count is unchanged. When full, a push is accepted only if a pop occurs in that cycle.
- Full without a same-cycle pop: the event is dropped, err_ovf pulses, and the FSM still returns to IDLE.
- Pointers wrap modulo DEPTH. Count is 0..DEPTH. fifo_full = (count==DEPTH).
- Error outputs are registered one-cycle pulses that assert in the cycle after the causing edge.
- Reset asserted mid-sequence or with a non-empty FIFO clears everything immediately. No event is emitted.

Test Plan:
- Byte stream 1C -> one event {1C,0,0}, out_valid=1 in the cycle after rx_done. Pop with out_rd -> out_valid=0.
- Byte stream F0,1C then E0,F0,75 -> events {1C,0,1} then {75,1,1} in order. No errors.
- Byte stream E0,E0,6B -> err_seq pulses once, then event {6B,1,0}. Byte stream E0,F0,F0 -> err_seq pulses, nothing is pushed, state is IDLE.
- Byte F0, then no byte for TIMEOUT_CYC cycles (set parameter to 16) -> err_to pulses once after 16 cycles. A following 1C gives {1C,0,0}, not a break.
- Push DEPTH+1 make codes 01..05 with DEPTH=4 and no pops -> fifo_full=1, err_ovf pulses on 05. Pops return 01..04. Separately: push while full with out_rd=1 in the same cycle -> accepted, no err_ovf.
- Assert reset after E0 with 2 events queued -> out_valid=0 and fifo_full=0 immediately. A following 74 gives {74,0,0}.

Source files
------------

// File: rtl/ps2_scancode_sequencer_if.sv
// Handshake bundle between the PS/2 byte receiver, the scan-code sequencer
// and the downstream event consumer.
interface ps2_scancode_sequencer_if;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       out_rd;
  logic       out_valid;
  logic [7:0] out_code;
  logic       out_ext;
  logic       out_brk;
  logic       fifo_full;
  logic       err_seq;
  logic       err_to;
  logic       err_ovf;

  // master: byte source and event consumer; slave: the sequencer itself
  modport master (
    output rx_data, rx_done, out_rd,
    input  out_valid, out_code, out_ext, out_brk, fifo_full,
    input  err_seq, err_to, err_ovf
  );

  modport slave (
    input  rx_data, rx_done, out_rd,
    output out_valid, out_code, out_ext, out_brk, fifo_full,
    output err_seq, err_to, err_ovf
  );
endinterface

// File: rtl/ps2_scancode_sequencer.sv
// Folds E0/F0-prefixed PS/2 byte sequences into {code, ext, brk} key events,
// buffers them in a small FIFO and flags bad prefix orders, stalls and overflow.
module ps2_scancode_sequencer #(
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int TO_W        = 20
) (
  input  logic                          clk,
  input  logic                          reset,
  ps2_scancode_sequencer_if.slave       bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0] B_EXT   = 8'hE0;
  localparam logic [7:0] B_BRK   = 8'hF0;
  localparam logic [7:0] B_PAUSE = 8'hE1;

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } event_t;

  state_t          state, state_nx;
  logic [TO_W-1:0] to_cnt;
  logic            to_hit;
  logic            push_req;
  event_t          push_ev;
  logic            seq_err, to_err;

  event_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            full, empty, pop, push_ok, ovf;

  assign to_hit = (state != IDLE) && (to_cnt == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // NOTE: every output of this combinational block gets a default first, so no
  // path through the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_nx = state;
    push_req = 1'b0;
    push_ev  = '{code: bus.rx_data, ext: 1'b0, brk: 1'b0};
    seq_err  = 1'b0;
    to_err   = 1'b0;
    if (bus.rx_done) begin
      if (bus.rx_data == B_PAUSE) begin
        seq_err  = 1'b1;
        state_nx = IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            if (bus.rx_data == B_EXT)      state_nx = EXT;
            else if (bus.rx_data == B_BRK) state_nx = BRK;
            else                           push_req = 1'b1;
          end
          EXT: begin
            if (bus.rx_data == B_BRK)      state_nx = EXT_BRK;
            else if (bus.rx_data == B_EXT) seq_err  = 1'b1;
            else begin
              push_req    = 1'b1;
              push_ev.ext = 1'b1;
              state_nx    = IDLE;
            end
          end
          BRK: begin
            // a duplicated F0 is tolerated; E0 restarts as an extended sequence
            if (bus.rx_data == B_EXT) begin
              seq_err  = 1'b1;
              state_nx = EXT;
            end else if (bus.rx_data != B_BRK) begin
              push_req    = 1'b1;
              push_ev.brk = 1'b1;
              state_nx    = IDLE;
            end
          end
          EXT_BRK: begin
            if (bus.rx_data == B_EXT || bus.rx_data == B_BRK) begin
              seq_err = 1'b1;
            end else begin
              push_req    = 1'b1;
              push_ev.ext = 1'b1;
              push_ev.brk = 1'b1;
            end
            state_nx = IDLE;
          end
          default: state_nx = IDLE;
        endcase
      end
    end else if (to_hit) begin
      to_err   = 1'b1;
      state_nx = IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                   to_cnt <= '0;
    else if (bus.rx_done || state == IDLE || to_hit) to_cnt <= '0;
    else                                         to_cnt <= to_cnt + 1'b1;
  end

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign pop     = bus.out_rd && !empty;
  assign push_ok = push_req && (!full || pop);
  assign ovf     = push_req && full && !pop;

  // NOTE: the event storage has no reset; validity is tracked by count, and
  // the head fields are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_ev;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)     rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      if (push_ok && !pop)      count <= count + 1'b1;
      else if (pop && !push_ok) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.err_seq <= 1'b0;
      bus.err_to  <= 1'b0;
      bus.err_ovf <= 1'b0;
    end else begin
      bus.err_seq <= seq_err;
      bus.err_to  <= to_err;
      bus.err_ovf <= ovf;
    end
  end

  event_t head;
  assign head          = empty ? '0 : mem[rd_ptr];
  assign bus.out_valid = !empty;
  assign bus.out_code  = head.code;
  assign bus.out_ext   = head.ext;
  assign bus.out_brk   = head.brk;
  assign bus.fifo_full = full;

endmodule

// File: tb/tb_ps2_scancode_sequencer.sv
// Directed bench for the scan-code sequencer: prefix decoding, error pulses,
// timeout, FIFO full/overflow and mid-sequence reset.
module tb_ps2_scancode_sequencer;

  localparam int DEPTH       = 4;
  localparam int TIMEOUT_CYC = 16;
  localparam int TO_W        = 5;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  ps2_scancode_sequencer_if bus ();

  ps2_scancode_sequencer #(
    .DEPTH(DEPTH), .TIMEOUT_CYC(TIMEOUT_CYC), .TO_W(TO_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Presents one byte for one clock edge (optionally popping in the same cycle)
  // and returns at the following falling edge, where registered pulses are visible.
  task automatic send(input logic [7:0] b, input logic rd = 1'b0);
    @(negedge clk);
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    bus.out_rd  = rd;
    @(negedge clk);
    bus.rx_done = 1'b0;
    bus.out_rd  = 1'b0;
    bus.rx_data = 8'h00;
  endtask

  task automatic pop_expect(input logic [7:0] code, input logic ext, input logic brk,
                            input string name);
    n_cmp++;
    if ({bus.out_valid, bus.out_code, bus.out_ext, bus.out_brk} !== {1'b1, code, ext, brk}) begin
      n_err++;
      $display("FAIL %s: got v=%b code=%h ext=%b brk=%b, expected v=1 code=%h ext=%b brk=%b",
               name, bus.out_valid, bus.out_code, bus.out_ext, bus.out_brk, code, ext, brk);
    end
    bus.out_rd = 1'b1;
    @(negedge clk);
    bus.out_rd = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({bus.out_valid, bus.fifo_full, bus.out_code, bus.out_ext, bus.out_brk,
         bus.err_seq, bus.err_to, bus.err_ovf} !== 15'h0) begin
      n_err++;
      $display("FAIL reset_state: got v=%b full=%b code=%h errs=%b%b%b, expected all 0",
               bus.out_valid, bus.fifo_full, bus.out_code, bus.err_seq, bus.err_to, bus.err_ovf);
    end
  endtask

  task automatic test_make();
    send(8'h1C);
    pop_expect(8'h1C, 1'b0, 1'b0, "make_1C");
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL make_pop_empty: got out_valid=%b, expected 0", bus.out_valid);
    end
  endtask

  task automatic test_break_ext();
    logic [7:0] seq [5] = '{8'hF0, 8'h1C, 8'hE0, 8'hF0, 8'h75};
    int errs = 0;
    foreach (seq[i]) begin
      send(seq[i]);
      if (bus.err_seq || bus.err_to || bus.err_ovf) errs++;
    end
    n_cmp++;
    if (errs !== 0) begin
      n_err++;
      $display("FAIL brk_ext_no_err: got %0d error pulses, expected 0", errs);
    end
    pop_expect(8'h1C, 1'b0, 1'b1, "brk_1C");
    pop_expect(8'h75, 1'b1, 1'b1, "ext_brk_75");
  endtask

  task automatic test_seq_err();
    logic [7:0] a [3] = '{8'hE0, 8'hE0, 8'h6B};
    logic       ea[3] = '{1'b0, 1'b1, 1'b0};
    logic [7:0] b [3] = '{8'hE0, 8'hF0, 8'hF0};
    logic       eb[3] = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      send(a[i]);
      n_cmp++;
      if (bus.err_seq !== ea[i]) begin
        n_err++;
        $display("FAIL seq_e0e0_%0d: got err_seq=%b expected %b", i, bus.err_seq, ea[i]);
      end
    end
    pop_expect(8'h6B, 1'b1, 1'b0, "seq_e0e0_6B");
    for (int i = 0; i < 3; i++) begin
      send(b[i]);
      n_cmp++;
      if (bus.err_seq !== eb[i]) begin
        n_err++;
        $display("FAIL seq_e0f0f0_%0d: got err_seq=%b expected %b", i, bus.err_seq, eb[i]);
      end
    end
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL seq_nothing_pushed: got out_valid=%b expected 0", bus.out_valid);
    end
    send(8'h1C);
    pop_expect(8'h1C, 1'b0, 1'b0, "seq_back_idle");
  endtask

  task automatic test_timeout();
    int early = 0;
    send(8'hF0);
    // err_to must stay low for 15 cycles after the F0 edge and rise after the 16th
    for (int i = 1; i < TIMEOUT_CYC; i++) begin
      @(negedge clk);
      if (bus.err_to) early++;
    end
    n_cmp++;
    if (early !== 0) begin
      n_err++;
      $display("FAIL to_early: got %0d early err_to cycles, expected 0", early);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.err_to !== 1'b1) begin
      n_err++;
      $display("FAIL to_pulse: got err_to=%b expected 1", bus.err_to);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.err_to !== 1'b0) begin
      n_err++;
      $display("FAIL to_one_cycle: got err_to=%b expected 0", bus.err_to);
    end
    send(8'h1C);
    pop_expect(8'h1C, 1'b0, 1'b0, "to_then_make");
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 4; i++) send(8'(i));
    n_cmp++;
    if (bus.fifo_full !== 1'b1 || bus.err_ovf !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_full: got full=%b ovf=%b expected full=1 ovf=0", bus.fifo_full, bus.err_ovf);
    end
    send(8'h05);
    n_cmp++;
    if (bus.err_ovf !== 1'b1 || bus.fifo_full !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_drop: got ovf=%b full=%b expected ovf=1 full=1", bus.err_ovf, bus.fifo_full);
    end
    for (int i = 1; i <= 4; i++) pop_expect(8'(i), 1'b0, 1'b0, $sformatf("ovf_pop_%0d", i));
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_empty: got out_valid=%b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 4; i++) send(8'(i));
    send(8'h05, 1'b1);
    n_cmp++;
    if (bus.err_ovf !== 1'b0 || bus.fifo_full !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_push_pop: got ovf=%b full=%b expected ovf=0 full=1", bus.err_ovf, bus.fifo_full);
    end
    for (int i = 2; i <= 5; i++) pop_expect(8'(i), 1'b0, 1'b0, $sformatf("b2b_pop_%0d", i));
  endtask

  task automatic test_mid_reset();
    send(8'h11);
    send(8'h22);
    send(8'hE0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.fifo_full !== 1'b0) begin
      n_err++;
      $display("FAIL rst_clear: got v=%b full=%b expected 0 0", bus.out_valid, bus.fifo_full);
    end
    @(negedge clk);
    reset = 1'b0;
    send(8'h74);
    pop_expect(8'h74, 1'b0, 1'b0, "rst_then_74");
  endtask

  initial begin
    reset       = 1'b1;
    bus.rx_data = 8'h00;
    bus.rx_done = 1'b0;
    bus.out_rd  = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b0;
    test_make();
    test_break_ext();
    test_seq_err();
    test_timeout();
    test_overflow();
    test_back_to_back();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
